// File: rtl/programmer_pkg.sv
// Shared state encoding, timing-counter width and test opcodes for the
// CPU_UNIT programmer-port transmitter.
package programmer_pkg;

    localparam int TCW = 16;

    localparam logic [7:0] OP_SET_RLO   = 8'h18;
    localparam logic [7:0] OP_SEM_WRITE = 8'hC0;
    localparam logic [7:0] OP_SEM_READ  = 8'hDE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ENTER,
        ST_FETCH,
        ST_SETUP,
        ST_SCK_HI,
        ST_SCK_LO,
        ST_WAIT_ACK,
        ST_ACK_LOW,
        ST_COMMIT,
        ST_RELEASE
    } prog_state_e;

endpackage

// File: rtl/prog_byte_fifo.sv
// Synchronous {last,data} byte buffer with async-reset pointers; an extra
// wrap bit on each pointer distinguishes full from empty.
module prog_byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_ready,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees a slot, so a full buffer may still accept.
    assign o_ready   = !w_full || w_do_pop;
    assign w_do_push = i_push && o_ready && !i_flush;
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/programmer_link_tx.sv
// Host-side transmitter for the CPU_UNIT programmer port: buffers host bytes,
// strobes them out with SCK, commits with PCK. Optional PROG_ACK_WAIT_EN adds
// per-byte ACK handshaking with timeout abort.
module programmer_link_tx
    import programmer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned SCK_HI_CYC  = 1,
    parameter int unsigned SCK_LO_CYC  = 1,
    parameter int unsigned RELEASE_CYC = 20,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        HOST_Start,
    input  logic [7:0]  HOST_Data,
    input  logic        HOST_Valid,
    input  logic        HOST_Last,
    output logic        HOST_Ready,
    output logic [7:0]  PROGRAMMER_InputData,
    output logic        PROGRAMMER_SCK,
    output logic        PROGRAMMER_PCK,
    output logic        PROGRAMMER_Reset,
    input  logic        PROGRAMMER_ACK,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [15:0] BYTE_COUNT
);
    prog_state_e      r_state;
    prog_state_e      w_state_nxt;
    logic [TCW-1:0]   r_tcnt;
    logic [TCW-1:0]   w_tcnt_nxt;
    logic [7:0]       r_data;
    logic             r_last;
    logic [15:0]      r_count;
    logic             r_done;
    logic             r_error;
    logic             w_pop;
    logic             w_flush;
    logic             w_start_sess;
    logic             w_inc_cnt;
    logic             w_done_nxt;
    logic             w_err_set;
    logic             w_fifo_empty;
    logic [8:0]       w_fifo_rdata;

    prog_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_flush (w_flush),
        .i_push  (HOST_Valid),
        .i_wdata ({HOST_Last, HOST_Data}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_ready (HOST_Ready),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_tcnt_nxt   = r_tcnt + 1'b1;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        w_start_sess = 1'b0;
        w_inc_cnt    = 1'b0;
        w_done_nxt   = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tcnt_nxt = '0;
                if (HOST_Start) begin
                    w_state_nxt  = ST_ENTER;
                    w_start_sess = 1'b1;
                end
            end
            ST_ENTER: begin
                w_tcnt_nxt  = '0;
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_tcnt_nxt = '0;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_tcnt == TCW'(SETUP_CYC - 1)) begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = ST_SCK_HI;
                end
            end
            ST_SCK_HI: begin
                if (r_tcnt == TCW'(SCK_HI_CYC - 1)) begin
                    w_tcnt_nxt  = '0;
                    w_inc_cnt   = 1'b1;
                    w_state_nxt = ST_SCK_LO;
                end
            end
            ST_SCK_LO: begin
                if (r_tcnt == TCW'(SCK_LO_CYC - 1)) begin
                    w_tcnt_nxt = '0;
`ifdef PROG_ACK_WAIT_EN
                    w_state_nxt = ST_WAIT_ACK;
`else
                    w_state_nxt = r_last ? ST_COMMIT : ST_FETCH;
`endif
                end
            end
`ifdef PROG_ACK_WAIT_EN
            // Timeout abandons the session without a commit and discards queued bytes.
            ST_WAIT_ACK: begin
                if (PROGRAMMER_ACK) begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = ST_ACK_LOW;
                end else if (r_tcnt == TCW'(ACK_TIMEOUT)) begin
                    w_err_set   = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACK_LOW: begin
                if (!PROGRAMMER_ACK) begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = r_last ? ST_COMMIT : ST_FETCH;
                end else if (r_tcnt == TCW'(ACK_TIMEOUT)) begin
                    w_err_set   = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            ST_COMMIT: begin
                w_tcnt_nxt  = '0;
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (r_tcnt == TCW'(RELEASE_CYC - 1)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_pop) begin
                {r_last, r_data} <= w_fifo_rdata;
            end
            if (w_start_sess) begin
                r_count <= '0;
            end else if (w_inc_cnt && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
            if (w_start_sess) begin
                r_error <= 1'b0;
            end else if (w_err_set) begin
                r_error <= 1'b1;
            end
        end
    end

`ifndef PROG_ACK_WAIT_EN
    logic w_unused_ack;
    assign w_unused_ack = PROGRAMMER_ACK & (ACK_TIMEOUT != 0);
`endif

    assign PROGRAMMER_InputData = r_data;
    assign PROGRAMMER_SCK       = (r_state == ST_SCK_HI);
    assign PROGRAMMER_PCK       = (r_state == ST_COMMIT);
    assign PROGRAMMER_Reset     = (r_state != ST_IDLE);
    assign BUSY                 = (r_state != ST_IDLE);
    assign DONE                 = r_done;
    assign ERROR                = r_error;
    assign BYTE_COUNT           = r_count;

endmodule

// File: tb/tb_programmer_link_tx.sv
// Self-checking bench for programmer_link_tx: cycle-level reference model plus
// directed sessions with literal expectations (ACK sessions need PROG_ACK_WAIT_EN).
`timescale 1ns/1ps
module tb_programmer_link_tx;
    import programmer_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SETC  = 1;
    localparam int unsigned HIC   = 1;
    localparam int unsigned LOC   = 1;
    localparam int unsigned RELC  = 20;
    localparam int unsigned TMO   = 255;
    localparam int unsigned PER   = SETC + HIC + LOC + 1;

    localparam int PH_IDLE = 0, PH_ENTER = 1, PH_BYTE = 2, PH_TAIL = 3, PH_ACKH = 4, PH_ACKL = 5;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        HOST_Start = 1'b0;
    logic [7:0]  HOST_Data = '0;
    logic        HOST_Valid = 1'b0;
    logic        HOST_Last = 1'b0;
    logic        PROGRAMMER_ACK = 1'b0;
    logic        HOST_Ready;
    logic [7:0]  PROGRAMMER_InputData;
    logic        PROGRAMMER_SCK;
    logic        PROGRAMMER_PCK;
    logic        PROGRAMMER_Reset;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;
    logic [15:0] BYTE_COUNT;

    programmer_link_tx #(
        .FIFO_DEPTH  (DEPTH),
        .SETUP_CYC   (SETC),
        .SCK_HI_CYC  (HIC),
        .SCK_LO_CYC  (LOC),
        .RELEASE_CYC (RELC),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .HOST_Start           (HOST_Start),
        .HOST_Data            (HOST_Data),
        .HOST_Valid           (HOST_Valid),
        .HOST_Last            (HOST_Last),
        .HOST_Ready           (HOST_Ready),
        .PROGRAMMER_InputData (PROGRAMMER_InputData),
        .PROGRAMMER_SCK       (PROGRAMMER_SCK),
        .PROGRAMMER_PCK       (PROGRAMMER_PCK),
        .PROGRAMMER_Reset     (PROGRAMMER_Reset),
        .PROGRAMMER_ACK       (PROGRAMMER_ACK),
        .BUSY                 (BUSY),
        .DONE                 (DONE),
        .ERROR                (ERROR),
        .BYTE_COUNT           (BYTE_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    logic [8:0]  mq[$];
    int          m_phase, m_pos, m_tail, m_k;
    logic [7:0]  m_data;
    logic        m_last, m_done, m_err;
    logic [15:0] m_count;
    logic        mv_pop, mv_push, mv_abort;
    logic [8:0]  mv_ent;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mq.delete();
            m_phase = PH_IDLE; m_pos = 0; m_tail = 0; m_k = 0;
            m_data = '0; m_last = 1'b0; m_done = 1'b0; m_err = 1'b0; m_count = '0;
        end else begin
            mv_pop   = (m_phase == PH_BYTE) && (m_pos == 0) && (mq.size() != 0);
            mv_push  = HOST_Valid && ((mq.size() < DEPTH) || mv_pop);
            mv_abort = 1'b0;
            m_done   = 1'b0;
            case (m_phase)
                PH_IDLE: if (HOST_Start) begin
                    m_phase = PH_ENTER; m_count = '0; m_err = 1'b0;
                end
                PH_ENTER: begin m_phase = PH_BYTE; m_pos = 0; end
                PH_BYTE: begin
                    if (m_pos == 0) begin
                        if (mv_pop) begin
                            mv_ent = mq.pop_front();
                            m_last = mv_ent[8]; m_data = mv_ent[7:0]; m_pos = 1;
                        end
                    end else if (m_pos == SETC + HIC) begin
                        m_pos++;
                        if (m_count != 16'hFFFF) m_count++;
                    end else if (m_pos == PER - 1) begin
`ifdef PROG_ACK_WAIT_EN
                        m_phase = PH_ACKH; m_k = 0;
`else
                        if (m_last) begin m_phase = PH_TAIL; m_tail = 0; end
                        else m_pos = 0;
`endif
                    end else begin
                        m_pos++;
                    end
                end
                PH_TAIL: begin
                    if (m_tail == RELC) begin m_phase = PH_IDLE; m_done = 1'b1; end
                    else m_tail++;
                end
                PH_ACKH: begin
                    if (PROGRAMMER_ACK) begin m_phase = PH_ACKL; m_k = 0; end
                    else if (m_k == TMO) mv_abort = 1'b1;
                    else m_k++;
                end
                PH_ACKL: begin
                    if (!PROGRAMMER_ACK) begin
                        if (m_last) begin m_phase = PH_TAIL; m_tail = 0; end
                        else begin m_phase = PH_BYTE; m_pos = 0; end
                    end else if (m_k == TMO) mv_abort = 1'b1;
                    else m_k++;
                end
                default: m_phase = PH_IDLE;
            endcase
            if (mv_push) mq.push_back({HOST_Last, HOST_Data});
            if (mv_abort) begin mq.delete(); m_phase = PH_IDLE; m_err = 1'b1; end
        end
    end

    // ---------------- compare / monitor ----------------
    logic [7:0] rx[$];
    int cyc = 0, pck_cnt = 0, pck_cyc = 0, done_cnt = 0, done_cyc = 0, rst_fall_cyc = 0;
    logic p_sck = 1'b0, p_rst = 1'b0;
    logic e_sck, e_ready, e_err;

    always @(posedge CLK) begin
        #2;
        cyc++;
        if (!RESET) begin
            if (PROGRAMMER_SCK && !p_sck) rx.push_back(PROGRAMMER_InputData);
            if (PROGRAMMER_PCK) begin pck_cnt++; pck_cyc = cyc; end
            if (!PROGRAMMER_Reset && p_rst) rst_fall_cyc = cyc;
            if (DONE) begin done_cnt++; done_cyc = cyc; end
            e_sck   = (m_phase == PH_BYTE) && (m_pos >= SETC + 1) && (m_pos <= SETC + HIC);
            e_ready = (mq.size() < DEPTH) || ((m_phase == PH_BYTE) && (m_pos == 0) && (mq.size() != 0));
`ifdef PROG_ACK_WAIT_EN
            e_err = m_err;
`else
            e_err = 1'b0;
`endif
            chk("model_ready", HOST_Ready, e_ready);
            chk("model_sck", PROGRAMMER_SCK, e_sck);
            chk("model_pck", PROGRAMMER_PCK, (m_phase == PH_TAIL) && (m_tail == 0));
            chk("model_preset", PROGRAMMER_Reset, m_phase != PH_IDLE);
            chk("model_busy", BUSY, m_phase != PH_IDLE);
            chk("model_done", DONE, m_done);
            chk("model_error", ERROR, e_err);
            chk("model_data", PROGRAMMER_InputData, m_data);
            chk("model_count", BYTE_COUNT, m_count);
        end
        p_sck = PROGRAMMER_SCK;
        p_rst = PROGRAMMER_Reset;
    end

`ifdef PROG_ACK_WAIT_EN
    logic ack_auto = 1'b1;
    int   ack_dly = 0;
    logic ack_psck = 1'b0;
    always @(negedge CLK) begin
        PROGRAMMER_ACK = 1'b0;
        if (ack_auto) begin
            if (ack_psck && !PROGRAMMER_SCK) ack_dly = 3;
            else if (ack_dly > 0) begin
                ack_dly--;
                if (ack_dly == 0) PROGRAMMER_ACK = 1'b1;
            end
        end
        ack_psck = PROGRAMMER_SCK;
    end
`endif

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [7:0] d, input logic l);
        int n = 0;
        HOST_Valid = 1'b1; HOST_Data = d; HOST_Last = l;
        while (!HOST_Ready && n < 1000) begin @(negedge CLK); n++; end
        if (!HOST_Ready) bound_fail("push_ready");
        @(negedge CLK);
        HOST_Valid = 1'b0;
    endtask

    task automatic start();
        HOST_Start = 1'b1;
        @(negedge CLK);
        HOST_Start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        int n = 0;
        while (done_cnt == base && n < 3000) begin @(negedge CLK); n++; end
        if (done_cnt == base) bound_fail(name);
        @(negedge CLK);
    endtask

    logic [7:0] exp1 [5];
    int b_rx, b_pck, b_done, n;

    initial begin
        exp1 = '{OP_SET_RLO, OP_SEM_WRITE, 8'h01, OP_SEM_READ, 8'h01};
        repeat (3) @(negedge CLK);
        chk("rst_ready", HOST_Ready, 1'b1);
        chk("rst_sck", PROGRAMMER_SCK, 1'b0);
        chk("rst_pck", PROGRAMMER_PCK, 1'b0);
        chk("rst_preset", PROGRAMMER_Reset, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_error", ERROR, 1'b0);
        chk("rst_data", PROGRAMMER_InputData, 8'h00);
        chk("rst_count", BYTE_COUNT, 16'h0000);
        RESET = 1'b0;
        @(negedge CLK);

        // Session with the canonical five-byte program.
        b_rx = rx.size(); b_pck = pck_cnt; b_done = done_cnt;
        for (int i = 0; i < 5; i++) push(exp1[i], i == 4);
        start();
        wait_done(b_done, "t1_done_wait");
        chk("t1_nbytes", rx.size() - b_rx, 5);
        for (int i = 0; i < 5; i++) chk("t1_byte", (rx.size() > b_rx + i) ? rx[b_rx + i] : 8'hXX, exp1[i]);
        chk("t1_pck_pulses", pck_cnt - b_pck, 1);
        chk("t1_done_pulses", done_cnt - b_done, 1);
        chk("t1_release_gap", rst_fall_cyc - pck_cyc, RELC + 1);
        chk("t1_done_at_release", done_cyc, rst_fall_cyc);
        chk("t1_count", BYTE_COUNT, 16'd5);
        chk("t1_model_count", m_count, 16'd5);
        chk("t1_data_held", PROGRAMMER_InputData, 8'h01);

        // Overfill without Start: 17th byte waits for the first pop.
        b_rx = rx.size(); b_done = done_cnt;
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 1'b0);
        chk("t2_full_ready", HOST_Ready, 1'b0);
        HOST_Valid = 1'b1; HOST_Data = 8'h5A; HOST_Last = 1'b1;
        repeat (5) @(negedge CLK);
        chk("t2_held_ready", HOST_Ready, 1'b0);
        start();
        n = 0;
        while (!HOST_Ready && n < 100) begin @(negedge CLK); n++; end
        if (!HOST_Ready) bound_fail("t2_accept");
        @(negedge CLK);
        HOST_Valid = 1'b0;
        wait_done(b_done, "t2_done_wait");
        chk("t2_nbytes", rx.size() - b_rx, 17);
        chk("t2_first", (rx.size() > b_rx) ? rx[b_rx] : 8'hXX, 8'h40);
        chk("t2_last", (rx.size() > b_rx + 16) ? rx[b_rx + 16] : 8'hXX, 8'h5A);
        chk("t2_count", BYTE_COUNT, 16'd17);

        // Host underrun: session held open with SCK idle.
        b_rx = rx.size(); b_done = done_cnt;
        start();
        repeat (50) @(negedge CLK);
        chk("t3_reset_held", PROGRAMMER_Reset, 1'b1);
        chk("t3_no_sck", rx.size() - b_rx, 0);
        chk("t3_count_zero", BYTE_COUNT, 16'd0);
        push(OP_SEM_READ, 1'b1);
        wait_done(b_done, "t3_done_wait");
        chk("t3_byte", (rx.size() > b_rx) ? rx[b_rx] : 8'hXX, OP_SEM_READ);
        chk("t3_count", BYTE_COUNT, 16'd1);

        // Asynchronous abort during the third SCK high phase.
        b_rx = rx.size();
        for (int i = 0; i < 5; i++) push(8'h70 + 8'(i), i == 4);
        start();
        n = 0;
        while (rx.size() < b_rx + 3 && n < 500) begin @(negedge CLK); n++; end
        if (rx.size() < b_rx + 3) bound_fail("t4_third_sck");
        chk("t4_sck_before", PROGRAMMER_SCK, 1'b1);
        RESET = 1'b1;
        #1;
        chk("t4_sck", PROGRAMMER_SCK, 1'b0);
        chk("t4_preset", PROGRAMMER_Reset, 1'b0);
        chk("t4_pck", PROGRAMMER_PCK, 1'b0);
        chk("t4_busy", BUSY, 1'b0);
        chk("t4_ready", HOST_Ready, 1'b1);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        b_rx = rx.size(); b_done = done_cnt;
        push(OP_SET_RLO, 1'b0);
        push(OP_SEM_WRITE, 1'b1);
        start();
        wait_done(b_done, "t4_done_wait");
        chk("t4_nbytes", rx.size() - b_rx, 2);
        chk("t4_byte0", (rx.size() > b_rx) ? rx[b_rx] : 8'hXX, OP_SET_RLO);
        chk("t4_count", BYTE_COUNT, 16'd2);

`ifdef PROG_ACK_WAIT_EN
        // ACK never arrives: timeout abort, no commit.
        ack_auto = 1'b0;
        b_pck = pck_cnt; b_done = done_cnt;
        push(8'hA1, 1'b0);
        push(8'hA2, 1'b1);
        start();
        n = 0;
        while (!ERROR && n < 1000) begin @(negedge CLK); n++; end
        if (!ERROR) bound_fail("t5_error_wait");
        @(negedge CLK);
        chk("t5_error", ERROR, 1'b1);
        chk("t5_no_pck", pck_cnt - b_pck, 0);
        chk("t5_no_done", done_cnt - b_done, 0);
        chk("t5_preset", PROGRAMMER_Reset, 1'b0);
        chk("t5_busy", BUSY, 1'b0);
        chk("t5_count", BYTE_COUNT, 16'd1);

        // ACK returned three cycles after each SCK fall.
        ack_auto = 1'b1;
        b_rx = rx.size(); b_done = done_cnt;
        push(8'hB1, 1'b0);
        push(8'hB2, 1'b0);
        push(8'hB3, 1'b1);
        start();
        wait_done(b_done, "t6_done_wait");
        chk("t6_nbytes", rx.size() - b_rx, 3);
        chk("t6_error", ERROR, 1'b0);
        chk("t6_count", BYTE_COUNT, 16'd3);
`endif

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
